// File: rtl/ntt_pingpong_buf.sv
// Two-bank ping-pong buffer between the NTT butterfly producer and its consumer.
// Optional macro NTT_BUF_RDREG_EN registers rd_data (1-cycle latency); default is combinational read.
module ntt_pingpong_buf #(
  parameter int DW = 96,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [DW-1:0] i_wr_data,
  input  logic          i_wr_done,
  output logic          o_wr_ready,
  output logic          o_wr_bank,
  input  logic [AW-1:0] i_rd_addr,
  output logic [DW-1:0] o_rd_data,
  input  logic          i_rd_done,
  output logic          o_rd_valid,
  output logic          o_rd_bank,
  output logic [1:0]    o_full_cnt,
  output logic          o_err
);

  localparam int NWORDS = 2 * (2 ** AW);

  logic [DW-1:0] r_mem [NWORDS];
  logic          r_wr_ptr;
  logic          r_rd_ptr;
  logic [1:0]    r_full_cnt;
  logic          r_err;

  logic          w_wr_ready;
  logic          w_rd_valid;
  logic          w_wr_acc;
  logic          w_wh_acc;
  logic          w_rh_acc;
  logic          w_violation;
  logic [1:0]    w_full_cnt_nxt;
  logic [DW-1:0] w_rd_word;

  // Flags decode from registered count only, so no input reaches them combinationally.
  assign w_wr_ready  = (r_full_cnt != 2'd2);
  assign w_rd_valid  = (r_full_cnt != 2'd0);
  assign w_wr_acc    = i_wr_en   && w_wr_ready;
  assign w_wh_acc    = i_wr_done && w_wr_ready;
  assign w_rh_acc    = i_rd_done && w_rd_valid;
  assign w_violation = ((i_wr_en || i_wr_done) && !w_wr_ready) || (i_rd_done && !w_rd_valid);
  assign w_rd_word   = r_mem[{r_rd_ptr, i_rd_addr}];

  // Next occupancy count from the two accepted handovers.
  always_comb begin
    w_full_cnt_nxt = r_full_cnt;
    case ({w_wh_acc, w_rh_acc})
      2'b10:   w_full_cnt_nxt = r_full_cnt + 2'd1;
      2'b01:   w_full_cnt_nxt = r_full_cnt - 2'd1;
      default: w_full_cnt_nxt = r_full_cnt;
    endcase
  end

  // Bank ownership pointers, occupancy count and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_full_cnt <= 2'd0;
      r_err      <= 1'b0;
    end else begin
      if (w_wh_acc) r_wr_ptr <= ~r_wr_ptr;
      if (w_rh_acc) r_rd_ptr <= ~r_rd_ptr;
      r_full_cnt <= w_full_cnt_nxt;
      if (w_violation) r_err <= 1'b1;
    end
  end

  // Storage: cleared on reset; a write alongside wr_done lands in the old bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NWORDS; i++) r_mem[i] <= {DW{1'b0}};
    end else if (w_wr_acc) begin
      r_mem[{r_wr_ptr, i_wr_addr}] <= i_wr_data;
    end
  end

`ifdef NTT_BUF_RDREG_EN
  logic [DW-1:0] r_rd_data;

  // Read register samples the pre-handover bank and old (pre-write) contents.
  always_ff @(posedge clk) begin
    if (rst) r_rd_data <= {DW{1'b0}};
    else     r_rd_data <= w_rd_word;
  end

  assign o_rd_data = r_rd_data;
`else
  assign o_rd_data = w_rd_word;
`endif

  assign o_wr_ready = w_wr_ready;
  assign o_rd_valid = w_rd_valid;
  assign o_wr_bank  = r_wr_ptr;
  assign o_rd_bank  = r_rd_ptr;
  assign o_full_cnt = r_full_cnt;
  assign o_err      = r_err;

endmodule

// File: tb/tb_ntt_pingpong_buf.sv
// Self-checking bench for ntt_pingpong_buf: directed scenarios with literal pins,
// then randomized traffic compared every cycle against a bank/queue-level model.
module tb_ntt_pingpong_buf;
  localparam int DW = 96;
  localparam int AW = 5;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_done = 1'b0;
  logic          wr_ready;
  logic          wr_bank;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_done = 1'b0;
  logic          rd_valid;
  logic          rd_bank;
  logic [1:0]    full_cnt;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;

  ntt_pingpong_buf #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .i_wr_en(wr_en), .i_wr_addr(wr_addr), .i_wr_data(wr_data), .i_wr_done(wr_done),
    .o_wr_ready(wr_ready), .o_wr_bank(wr_bank),
    .i_rd_addr(rd_addr), .o_rd_data(rd_data), .i_rd_done(rd_done),
    .o_rd_valid(rd_valid), .o_rd_bank(rd_bank), .o_full_cnt(full_cnt), .o_err(err)
  );

  always #5 clk = ~clk;

  // Behavioural model: two banks as a flat word array plus owner indices and a count.
  logic [DW-1:0] m_mem [2*DEPTH];
  int            m_wr = 0;
  int            m_rd = 0;
  int            m_cnt = 0;
  bit            m_err = 1'b0;
  logic [DW-1:0] m_rdq = '0;
  bit            started = 1'b0;

  always @(posedge clk) begin
    bit wr_ok, rd_ok;
    if (rst) begin
      for (int i = 0; i < 2*DEPTH; i++) m_mem[i] = '0;
      m_wr = 0; m_rd = 0; m_cnt = 0; m_err = 1'b0; m_rdq = '0;
      started = 1'b1;
    end else begin
      m_rdq = m_mem[m_rd*DEPTH + int'(rd_addr)];
      wr_ok = (m_cnt < 2);
      rd_ok = (m_cnt > 0);
      if (wr_en && wr_ok) m_mem[m_wr*DEPTH + int'(wr_addr)] = wr_data;
      if ((wr_en || wr_done) && !wr_ok) m_err = 1'b1;
      if (rd_done && !rd_ok) m_err = 1'b1;
      if (wr_done && wr_ok) begin m_wr = 1 - m_wr; m_cnt = m_cnt + 1; end
      if (rd_done && rd_ok) begin m_rd = 1 - m_rd; m_cnt = m_cnt - 1; end
    end
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [DW-1:0] exp_rd;
    if (started) begin
`ifdef NTT_BUF_RDREG_EN
      exp_rd = m_rdq;
`else
      exp_rd = m_mem[m_rd*DEPTH + int'(rd_addr)];
`endif
      chk("full_cnt", DW'(full_cnt), DW'(m_cnt));
      chk("wr_ready", DW'(wr_ready), DW'(m_cnt != 2));
      chk("rd_valid", DW'(rd_valid), DW'(m_cnt != 0));
      chk("wr_bank",  DW'(wr_bank),  DW'(m_wr));
      chk("rd_bank",  DW'(rd_bank),  DW'(m_rd));
      chk("err",      DW'(err),      DW'(m_err));
      chk("rd_data",  rd_data,       exp_rd);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_done = 1'b0; rd_done = 1'b0;
  endtask

  task automatic do_reset();
    idle(); rst = 1'b1; tick(); rst = 1'b0;
  endtask

  logic [DW-1:0] pat_aa;

  initial begin
    pat_aa = {12{8'hAA}};
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    @(negedge clk);
    chk("rst_full_cnt", DW'(full_cnt), 96'd0);
    chk("rst_wr_ready", DW'(wr_ready), 96'd1);
    chk("rst_rd_valid", DW'(rd_valid), 96'd0);
    chk("rst_rd_data",  rd_data,       96'd0);
    tick();

    // Fill bank 0 with k+1 and hand it over.
    for (int k = 0; k < DEPTH; k++) begin
      wr_en = 1'b1; wr_addr = AW'(k); wr_data = DW'(k + 1); tick();
    end
    wr_en = 1'b0; wr_done = 1'b1; tick();
    wr_done = 1'b0; rd_addr = 5'd7; tick();
    @(negedge clk);
    chk("fill_rd_valid", DW'(rd_valid), 96'd1);
    chk("fill_rd_bank",  DW'(rd_bank),  96'd0);
    chk("fill_wr_bank",  DW'(wr_bank),  96'd1);
    chk("fill_full_cnt", DW'(full_cnt), 96'd1);
    chk("fill_rd7",      rd_data,       96'd8);

    // Overlap: fill bank 1 while reading bank 0, then swap both at once.
    for (int k = 0; k < DEPTH; k++) begin
      wr_en = 1'b1; wr_addr = AW'(k); wr_data = pat_aa; rd_addr = AW'($urandom_range(DEPTH-1)); tick();
    end
    wr_en = 1'b0; wr_done = 1'b1; rd_done = 1'b1; tick();
    idle(); rd_addr = 5'd3; tick();
    @(negedge clk);
    chk("ovl_full_cnt", DW'(full_cnt), 96'd1);
    chk("ovl_rd_bank",  DW'(rd_bank),  96'd1);
    chk("ovl_wr_bank",  DW'(wr_bank),  96'd0);
    chk("ovl_rd3",      rd_data,       pat_aa);

    // Last write with handover into bank 0, then overflow attempt into bank 1.
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 96'h123; wr_done = 1'b1; tick();
    idle(); tick();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 96'h5; tick();
    idle(); tick();
    @(negedge clk);
    chk("ovf_full_cnt", DW'(full_cnt), 96'd2);
    chk("ovf_wr_ready", DW'(wr_ready), 96'd0);
    chk("ovf_err",      DW'(err),      96'd1);
    rd_done = 1'b1; tick();
    idle(); rd_addr = 5'd31; tick();
    @(negedge clk);
    chk("last_rd_bank", DW'(rd_bank), 96'd0);
    chk("last_rd31",    rd_data,      96'h123);
    rd_done = 1'b1; tick();
    idle(); rd_addr = 5'd0; tick();
    @(negedge clk);
    chk("drop_rd0",  rd_data,  pat_aa);
    chk("err_stick", DW'(err), 96'd1);

    // Reset mid-drain with both banks full.
    wr_done = 1'b1; tick(); tick();
    idle(); tick();
    do_reset();
    @(negedge clk);
    chk("rmd_full_cnt", DW'(full_cnt), 96'd0);
    chk("rmd_err",      DW'(err),      96'd0);
    chk("rmd_rd_bank",  DW'(rd_bank),  96'd0);
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = AW'(a); tick();
    end

    // Underflow right after reset.
    do_reset();
    rd_done = 1'b1; tick();
    idle(); tick();
    @(negedge clk);
    chk("unf_full_cnt", DW'(full_cnt), 96'd0);
    chk("unf_rd_bank",  DW'(rd_bank),  96'd0);
    chk("unf_err",      DW'(err),      96'd1);

    // Randomized traffic, checked every cycle by the compare process.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst     = ($urandom_range(499) == 0);
      wr_en   = ($urandom_range(1) == 1);
      wr_addr = AW'($urandom);
      wr_data = {$urandom, $urandom, $urandom};
      wr_done = ($urandom_range(15) == 0);
      rd_done = ($urandom_range(15) == 0);
      rd_addr = AW'($urandom);
      tick();
    end
    idle(); rst = 1'b0; tick();
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/ntt_pingpong_buf.md
# ntt_pingpong_buf

Parametrised two-bank ping-pong buffer for the NTT datapath: one bank is filled by the producer (butterfly/twiddle stage) while the other is drained by the consumer, so load and compute overlap without stalls. Each bank holds 2**AW words of DW bits. Bank ownership is handed over with explicit done handshakes. A sticky error flag catches protocol violations.

## Interface
- DW, default 96: data word width in bits.
- AW, default 5: address width; each bank holds 2**AW words.

- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  write word wr_data to wr_addr in the current write bank.
- wr_addr  in  AW  write address within the write bank.
- wr_data  in  DW  write data.
- wr_done  in  1  producer hands the current write bank to the reader.
- wr_ready  out  1  a free bank is available for writing (full_cnt < 2).
- wr_bank  out  1  index of the current write bank.
- rd_addr  in  AW  read address within the read bank.
- rd_data  out  DW  read data.
- rd_done  in  1  consumer releases the current read bank.
- rd_valid  out  1  a full bank is available for reading (full_cnt > 0).
- rd_bank  out  1  index of the current read bank.
- full_cnt  out  2  number of banks handed to the reader and not yet released (0..2).
- err  out  1  sticky protocol-violation flag.

## Operation
- State: wr_ptr (1b), rd_ptr (1b), full_cnt (2b), err, and storage mem[2][2**AW] of DW bits.
- wr_bank = wr_ptr. rd_bank = rd_ptr. wr_ready = (full_cnt != 2). rd_valid = (full_cnt != 0).
- Write is accepted when wr_en && wr_ready: mem[wr_ptr][wr_addr] <= wr_data.
- Write handover is accepted when wr_done && wr_ready: wr_ptr toggles and full_cnt increments. A write in the same cycle lands in the old bank.
- Read handover is accepted when rd_done && rd_valid: rd_ptr toggles and full_cnt decrements.
- When both handovers are accepted in the same cycle, both pointers toggle and full_cnt is unchanged.
- Ignored requests:
  - wr_en or wr_done while !wr_ready: no write, no pointer change, err <= 1.
  - rd_done while !rd_valid: no change, err <= 1.
- err stays set until rst.
- Reads are never blocked. rd_data always reflects mem[rd_ptr][rd_addr], including when rd_valid = 0; contents are meaningful only when rd_valid = 1.
- Invariant: full_cnt == (wr_ptr != rd_ptr) ? 1 : (full_cnt is 0 or 2). The verifier checks this every cycle.
- Reset:
  - All 2*2**AW words clear to 0.
  - wr_ptr = rd_ptr = 0, full_cnt = 0, err = 0, rd_data = 0.
  - Hence wr_ready = 1 and rd_valid = 0.
  - Reset asserted mid-fill or mid-drain discards all contents and handovers.

## Timing
- Write: data is visible in storage from the cycle after the accepting edge.
- Handover: pointer, full_cnt, wr_ready and rd_valid change one cycle after the accepting edge. wr_done followed by rd_valid = 1 takes 1 cycle.
- Read-during-write to the same physical word in the same cycle returns old data (read-before-write) in both read modes.
- rd_data latency depends on NTT_BUF_RDREG_EN (see Configuration).
- No combinational path from wr_* or rd_done to wr_ready or rd_valid.

## Configuration
- NTT_BUF_RDREG_EN defined:
  - rd_data is a register loaded each edge with mem[rd_ptr][rd_addr], sampled at that edge (pre-handover rd_ptr).
  - Latency is 1 cycle.
  - The rd_data register clears to 0 on rst.
- NTT_BUF_RDREG_EN undefined:
  - rd_data is combinational from the current rd_ptr and rd_addr, with 0-cycle latency.
  - Immediately after rst it reads 0 because storage is cleared.

## Test plan
- Reset then fill: write addr k <= k+1 for k = 0..31 into bank 0, then pulse wr_done -> next cycle rd_valid = 1, rd_bank = 0, wr_bank = 1, full_cnt = 1; reading addr 7 returns 8 (one cycle later with NTT_BUF_RDREG_EN).
- Overlap: fill bank 1 with 0xAA.. while reading bank 0, then pulse rd_done and wr_done in the same cycle -> full_cnt stays 1, rd_bank = 1, wr_bank = 0; addr 3 reads 0xAA...
- Overflow: issue wr_done twice with no rd_done -> full_cnt = 2, wr_ready = 0; a third wr_en to addr 0 with 0x5 is dropped (bank contents unchanged) and err = 1 until rst.
- Underflow: pulse rd_done right after reset -> full_cnt = 0, rd_ptr = 0, err = 1.
- Last write with handover: in the same cycle write addr 31 <= 0x123 and pulse wr_done -> the word lands in the old bank; reading addr 31 of that bank later returns 0x123.
- Reset mid-drain: full_cnt = 2, assert rst for one cycle -> full_cnt = 0, pointers 0, err = 0, and every address reads 0.
